fc_argmax_6_20: RTL and testbench

//  Classifier stage directly downstream of the fc_M_N_T_R_P layer. Consumes the M signed
//  T-bit outputs the layer streams out per input vector (rows 0..M-1, in order).

---
 rtl/fc_argmax_6_20.sv | 75 +++++++
 tb/tb_fc_argmax_6_20.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fc_argmax_6_20.sv
// Argmax classifier stage: collects M signed values per vector and emits the index and value
// of the largest one. Ties keep the lower index.
module fc_argmax_6_20 #(
  parameter int M = 6,
  parameter int T = 20,
  localparam int LOGM = (M > 1) ? $clog2(M) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            input_valid,
  output logic            input_ready,
  input  logic [T-1:0]    input_data,
  output logic            output_valid,
  input  logic            output_ready,
  output logic [LOGM-1:0] output_data,
  output logic [T-1:0]    output_max
);

  // Handshake: a beat moves on either side only in a cycle where valid && ready are both
  // high at the rising edge; valid never waits on ready, and a raised output_valid holds
  // its data stable until that handshake.
  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [LOGM-1:0] LAST = LOGM'(M - 1);

  state_t                state;
  logic [LOGM-1:0]       count;
  logic [LOGM-1:0]       best_idx;
  logic signed [T-1:0]   best_val;
  logic                  in_acc;
  logic                  take;

  assign input_ready  = !reset && (state == COLLECT);
  assign in_acc       = input_valid && input_ready;
  // First beat always loads; later beats only on a strictly greater signed value.
  assign take         = (count == '0) || ($signed(input_data) > best_val);
  assign output_data  = best_idx;
  assign output_max   = best_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= COLLECT;
      count        <= '0;
      best_idx     <= '0;
      best_val     <= '0;
      output_valid <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (in_acc) begin
            if (take) begin
              best_val <= $signed(input_data);
              best_idx <= count;
            end
            if (count == LAST) begin
              count        <= '0;
              state        <= HOLD;
              output_valid <= 1'b1;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        HOLD: begin
          if (output_ready) begin
            state        <= COLLECT;
            output_valid <= 1'b0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_argmax_6_20.sv
// Self-checking bench for fc_argmax_6_20: drives vectors through the input handshake and
// checks each result beat against a queue of reference-model argmax results.
module tb_fc_argmax_6_20;
  localparam int M = 6;
  localparam int T = 20;
  localparam int LOGM = 3;
  localparam int W = LOGM + T;

  typedef logic signed [T-1:0] vec_t [M];

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            input_valid = 1'b0;
  logic            input_ready;
  logic [T-1:0]    input_data = '0;
  logic            output_valid;
  logic            output_ready = 1'b1;
  logic [LOGM-1:0] output_data;
  logic [T-1:0]    output_max;

  logic [W-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int pushed = 0;
  int popped = 0;

  fc_argmax_6_20 dut (
    .clk(clk), .reset(reset),
    .input_valid(input_valid), .input_ready(input_ready), .input_data(input_data),
    .output_valid(output_valid), .output_ready(output_ready),
    .output_data(output_data), .output_max(output_max)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference argmax: strictly-greater signed compare, lowest index wins ties
  function automatic logic [W-1:0] model(input vec_t v);
    logic signed [T-1:0] best;
    logic [LOGM-1:0] idx;
    best = v[0];
    idx = '0;
    for (int i = 1; i < M; i++)
      if (v[i] > best) begin
        best = v[i];
        idx = LOGM'(i);
      end
    return {idx, best};
  endfunction

  // drivers: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    input_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      input_data = T'($urandom);
      tick();
    end
  endtask

  task automatic send_beat(input logic [T-1:0] val);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    input_valid = 1'b1;
    input_data = val;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = input_ready;
      tick();
      n++;
    end
    if (!acc) check("beat_timeout", 32'd0, 32'd1);
    input_valid = 1'b0;
  endtask

  // gap < 0 picks a random idle gap of 0..3 cycles between beats
  task automatic send_vector(input vec_t v, input int gap);
    exp_q.push_back(model(v));
    pushed++;
    for (int i = 0; i < M; i++) begin
      send_beat(v[i]);
      if (i < M - 1) idle(gap < 0 ? int'($urandom_range(0, 3)) : gap);
    end
  endtask

  // scoreboard: compare on each output handshake, sampled at the falling edge
  always @(negedge clk) begin
    if (!reset && output_valid && output_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        popped++;
        check("idx", 32'(output_data), 32'(e[W-1:T]));
        check("max", 32'(output_max), 32'(e[T-1:0]));
      end
    end
  end

  initial begin
    vec_t v;
    logic [LOGM-1:0] held_idx;
    logic [T-1:0] held_max;
    int n;

    // reset state
    reset = 1'b1;
    input_valid = 1'b1;
    input_data = 20'h12345;
    tick();
    tick();
    @(negedge clk);
    check("rst_input_ready", 32'(input_ready), 32'd0);
    check("rst_output_valid", 32'(output_valid), 32'd0);
    check("rst_output_data", 32'(output_data), 32'd0);
    check("rst_output_max", 32'(output_max), 32'd0);
    tick();
    reset = 1'b0;
    input_valid = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(input_ready), 32'd1);
    tick();

    // 1: tie keeps lower index; latency of exactly one cycle after the last accept
    v = '{20'sd5, 20'sd9, 20'sd3, 20'sd9, -20'sd2, 20'sd1};
    exp_q.push_back(model(v));
    pushed++;
    for (int i = 0; i < M; i++) begin
      send_beat(v[i]);
      if (i == M - 2) check("valid_before_last", 32'(output_valid), 32'd0);
    end
    check("latency_valid", 32'(output_valid), 32'd1);
    check("hold_ready", 32'(input_ready), 32'd0);
    tick();
    check("valid_dropped", 32'(output_valid), 32'd0);

    // 2: all negative, includes the most negative T-bit value
    v = '{-20'sd7, -20'sd3, -20'sd3, -20'sd100, -20'sd524288, -20'sd4};
    send_vector(v, 0);
    idle(2);

    // 3: valid gaps of two cycles between beats
    v = '{20'sd0, 20'sd0, 20'sd0, 20'sd0, 20'sd0, 20'sd524287};
    send_vector(v, 2);
    idle(2);

    // 4: output stalled for 10 cycles while upstream keeps valid high
    output_ready = 1'b0;
    v = '{20'sd10, -20'sd20, 20'sd30, 20'sd30, -20'sd1, 20'sd29};
    send_vector(v, 0);
    held_idx = 3'd2;
    held_max = 20'd30;
    input_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      input_data = T'($urandom);
      @(negedge clk);
      check("stall_valid", 32'(output_valid), 32'd1);
      check("stall_ready", 32'(input_ready), 32'd0);
      check("stall_idx", 32'(output_data), 32'(held_idx));
      check("stall_max", 32'(output_max), 32'(held_max));
      tick();
    end
    input_valid = 1'b0;
    output_ready = 1'b1;
    tick();
    @(negedge clk);
    check("release_ready", 32'(input_ready), 32'd1);
    check("release_valid", 32'(output_valid), 32'd0);
    tick();

    // 5: reset after 3 of 6 beats discards the partial vector
    send_beat(20'sd100);
    send_beat(20'sd200);
    send_beat(20'sd300);
    reset = 1'b1;
    input_valid = 1'b1;
    @(negedge clk);
    check("midrst_ready", 32'(input_ready), 32'd0);
    tick();
    reset = 1'b0;
    input_valid = 1'b0;
    @(negedge clk);
    check("midrst_output_max", 32'(output_max), 32'd0);
    check("midrst_output_valid", 32'(output_valid), 32'd0);
    tick();
    v = '{20'sd1, 20'sd2, 20'sd3, 20'sd4, 20'sd5, 20'sd6};
    send_vector(v, 0);

    // 6: back-to-back vectors, max at index 0 then at index 5
    v = '{20'sd50, 20'sd1, 20'sd2, 20'sd3, 20'sd4, 20'sd5};
    send_vector(v, 0);
    v = '{-20'sd9, -20'sd8, -20'sd7, -20'sd6, -20'sd5, 20'sd0};
    send_vector(v, 0);

    // random vectors with random gaps over the full signed range
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < M; i++)
        v[i] = ($urandom_range(0, 3) == 0) ? v[(i + 5) % M] : T'($urandom);
      send_vector(v, -1);
    end

    // drain
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("result_count", 32'(popped), 32'(pushed));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
